// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//   SDRAM self-test engine driving the sdram_ctrl request interface. After the
//   power-up wait, a start pulse writes a seed-derived pattern over
//   [START_ADDR, END_ADDR], reads the range back one word at a time and
//   compares each word against the regenerated pattern. Nothing is buffered:
//   the expected word is recomputed from (mode, seed, index) during read-back.
//
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   start, mode, seed     : start pulse (IDLE only); pattern select and seed,
//                           both latched on start
//   sdram_req/ack         : request to controller, one-cycle acceptance
//   sdram_addr, sdram_rh_wl, sdram_data_w : request address, 1=read 0=write,
//                           write data; held stable until acked
//   sdram_data_r(_en)     : read data and its strobe
//   busy, done, pass, timeout : test status; done/pass/timeout held until
//                           the next start
//   err_cnt               : saturating mismatch count
//   first_err_addr        : address of the first mismatch
//   led                   : 00 init/idle, 01 busy, 55 passed, AA failed
//
// state  | meaning
// -------+-----------------------------------------------------------------
// INIT   | power-up wait, start ignored
// IDLE   | waiting for start
// WR     | write stream; req high = waiting for ack, req low = one-cycle gap
// RD     | read request; req high = waiting for ack, req low = one-cycle gap
// RDATA  | read accepted, waiting for the data strobe
// DONE   | one-cycle wrap-up before returning to IDLE with done set

module sdram_pattern_tester #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 255,
   parameter int INIT_WAIT  = 25000,
   parameter int TIMEOUT    = 1023,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic                  sdram_req,
   input  logic                  sdram_ack,
   output logic [ADDR_WIDTH-1:0] sdram_addr,
   output logic                  sdram_rh_wl,
   output logic [DATA_WIDTH-1:0] sdram_data_w,
   input  logic [DATA_WIDTH-1:0] sdram_data_r,
   input  logic                  sdram_data_r_en,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [ERR_WIDTH-1:0]  err_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [7:0]            led
);

   localparam int INIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Both timers run downward from their load value to zero; reaching zero is
   // the same instant as an up-counter reaching INIT_WAIT-1 / TIMEOUT.
   localparam logic [INIT_W-1:0]     INIT_LOAD = INIT_W'(INIT_WAIT - 1);
   localparam logic [TMO_W-1:0]      TMO_LOAD  = TMO_W'(TIMEOUT);
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(END_ADDR - START_ADDR);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RDATA,
      ST_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [INIT_W-1:0]     init_cnt, init_cnt_nxt;
   logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
   logic [ADDR_WIDTH-1:0] idx, idx_nxt;
   logic [1:0]            mode_q, mode_nxt;
   logic [DATA_WIDTH-1:0] seed_q, seed_nxt;

   logic                  req_nxt;
   logic                  rh_wl_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] data_w_nxt;
   logic                  busy_nxt;
   logic                  done_nxt;
   logic                  pass_nxt;
   logic                  timeout_nxt;
   logic [ERR_WIDTH-1:0]  err_cnt_nxt;
   logic [ADDR_WIDTH-1:0] first_err_nxt;
   logic [7:0]            led_nxt;

   logic                  ack_ok;
   logic                  strobe_ok;
   logic [DATA_WIDTH-1:0] exp_word;
   logic [ADDR_WIDTH-1:0] cur_addr;

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            m,
      input logic [DATA_WIDTH-1:0] s,
      input logic [ADDR_WIDTH-1:0] i
   );
      logic [DATA_WIDTH-1:0] w;
      case (m)
         2'd0:    w = s;
         2'd1:    w = s + DATA_WIDTH'(i);
         2'd2:    w = s ^ DATA_WIDTH'(BASE_ADDR + i);
         default: w = i[0] ? ~s : s;
      endcase
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_INIT;
         init_cnt       <= INIT_LOAD;
         tmo_cnt        <= TMO_LOAD;
         idx            <= '0;
         mode_q         <= '0;
         seed_q         <= '0;
         sdram_req      <= 1'b0;
         sdram_rh_wl    <= 1'b1;
         sdram_addr     <= '0;
         sdram_data_w   <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         led            <= 8'h00;
      end else begin
         state          <= state_nxt;
         init_cnt       <= init_cnt_nxt;
         tmo_cnt        <= tmo_cnt_nxt;
         idx            <= idx_nxt;
         mode_q         <= mode_nxt;
         seed_q         <= seed_nxt;
         sdram_req      <= req_nxt;
         sdram_rh_wl    <= rh_wl_nxt;
         sdram_addr     <= addr_nxt;
         sdram_data_w   <= data_w_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         pass           <= pass_nxt;
         timeout        <= timeout_nxt;
         err_cnt        <= err_cnt_nxt;
         first_err_addr <= first_err_nxt;
         led            <= led_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      init_cnt_nxt  = init_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      idx_nxt       = idx;
      mode_nxt      = mode_q;
      seed_nxt      = seed_q;
      req_nxt       = sdram_req;
      rh_wl_nxt     = sdram_rh_wl;
      addr_nxt      = sdram_addr;
      data_w_nxt    = sdram_data_w;
      done_nxt      = done;
      timeout_nxt   = timeout;
      err_cnt_nxt   = err_cnt;
      first_err_nxt = first_err_addr;
      busy_nxt      = 1'b0;
      pass_nxt      = 1'b0;
      led_nxt       = 8'h00;
      ack_ok        = 1'b0;
      strobe_ok     = 1'b0;
      exp_word      = pattern(mode_q, seed_q, idx);
      cur_addr      = BASE_ADDR + idx;

      case (state)
         ST_INIT: begin
            if (init_cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               init_cnt_nxt = init_cnt - INIT_W'(1);
            end
         end

         ST_IDLE: begin
            if (start) begin
               state_nxt     = ST_WR;
               mode_nxt      = mode;
               seed_nxt      = seed;
               idx_nxt       = '0;
               err_cnt_nxt   = '0;
               first_err_nxt = '0;
               done_nxt      = 1'b0;
               timeout_nxt   = 1'b0;
               // first write goes out on the very next cycle
               req_nxt       = 1'b1;
               rh_wl_nxt     = 1'b0;
               addr_nxt      = BASE_ADDR;
               data_w_nxt    = pattern(mode, seed, '0);
            end
         end

         ST_WR: begin
            if (sdram_req && sdram_ack) begin
               ack_ok  = 1'b1;
               req_nxt = 1'b0;
               if (idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  state_nxt = ST_RD;
               end else begin
                  idx_nxt = idx + ADDR_WIDTH'(1);
               end
            end else if (tmo_cnt == '0) begin
               timeout_nxt = 1'b1;
               req_nxt     = 1'b0;
               state_nxt   = ST_DONE;
            end else if (!sdram_req) begin
               req_nxt    = 1'b1;
               rh_wl_nxt  = 1'b0;
               addr_nxt   = cur_addr;
               data_w_nxt = exp_word;
            end
         end

         ST_RD: begin
            if (sdram_req && sdram_ack) begin
               ack_ok    = 1'b1;
               req_nxt   = 1'b0;
               state_nxt = ST_RDATA;
            end else if (tmo_cnt == '0) begin
               timeout_nxt = 1'b1;
               req_nxt     = 1'b0;
               state_nxt   = ST_DONE;
            end else if (!sdram_req) begin
               req_nxt   = 1'b1;
               rh_wl_nxt = 1'b1;
               addr_nxt  = cur_addr;
            end
         end

         ST_RDATA: begin
            if (sdram_data_r_en) begin
               strobe_ok = 1'b1;
               if (sdram_data_r != exp_word) begin
                  if (err_cnt == '0) begin
                     first_err_nxt = cur_addr;
                  end
                  if (!(&err_cnt)) begin
                     err_cnt_nxt = err_cnt + ERR_WIDTH'(1);
                  end
               end
               if (idx == LAST_IDX) begin
                  state_nxt = ST_DONE;
               end else begin
                  idx_nxt   = idx + ADDR_WIDTH'(1);
                  state_nxt = ST_RD;
               end
            end else if (tmo_cnt == '0) begin
               timeout_nxt = 1'b1;
               state_nxt   = ST_DONE;
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end

         default: begin
            state_nxt = ST_INIT;
         end
      endcase

      // watchdog restarts on any state change or controller handshake
      if ((state_nxt != state) || ack_ok || strobe_ok) begin
         tmo_cnt_nxt = TMO_LOAD;
      end else if (((state == ST_WR) || (state == ST_RD) || (state == ST_RDATA)) &&
                   (tmo_cnt != '0)) begin
         tmo_cnt_nxt = tmo_cnt - TMO_W'(1);
      end

      busy_nxt = (state_nxt == ST_WR) || (state_nxt == ST_RD) ||
                 (state_nxt == ST_RDATA) || (state_nxt == ST_DONE);
      pass_nxt = done_nxt && (err_cnt_nxt == '0) && !timeout_nxt;

      if (state_nxt == ST_INIT) begin
         led_nxt = 8'h00;
      end else if (busy_nxt) begin
         led_nxt = 8'h01;
      end else if (done_nxt && pass_nxt) begin
         led_nxt = 8'h55;
      end else if (done_nxt) begin
         led_nxt = 8'hAA;
      end else begin
         led_nxt = 8'h00;
      end
   end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a small SDRAM controller model
// (configurable ack/read latency, per-address read corruption, a write that is
// never acked) and a bus monitor for request hold and gap timing.
`timescale 1ns/1ps
module tb_sdram_pattern_tester;

   localparam int AW  = 24;
   localparam int DW  = 16;
   localparam int IW  = 20;
   localparam int EW  = 2;
   localparam int TMO = 1023;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [DW-1:0] seed = '0;
   logic          sdram_req;
   logic          sdram_ack = 1'b0;
   logic [AW-1:0] sdram_addr;
   logic          sdram_rh_wl;
   logic [DW-1:0] sdram_data_w;
   logic [DW-1:0] sdram_data_r = '0;
   logic          sdram_data_r_en = 1'b0;
   logic          busy, done, pass, timeout;
   logic [EW-1:0] err_cnt;
   logic [AW-1:0] first_err_addr;
   logic [7:0]    led;

   sdram_pattern_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .END_ADDR(7),
      .INIT_WAIT(IW), .TIMEOUT(TMO), .ERR_WIDTH(EW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
      .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
      .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w),
      .sdram_data_r(sdram_data_r), .sdram_data_r_en(sdram_data_r_en),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr), .led(led)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model knobs, written only by the stimulus block
   int         ack_lat = 3;
   int         rd_lat = 3;
   int         no_ack_wr = -1;
   logic [7:0] corrupt = 8'h00;

   // model / monitor state
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] wr_log [0:15];
   int            ack_wait = 0, rd_wait = 0, wr_cnt = 0, rd_cnt = 0;
   logic          rd_pend = 1'b0;
   logic [7:0]    rd_addr = '0;
   int            last_rise_cyc = 0, last_strobe_cyc = 0, low_run = 0;
   int            gap_bad = 0, hold_bad = 0;
   logic          have_prev = 1'b0, prev_rise_wr = 1'b0, req_prev = 1'b0, rh_prev = 1'b1;
   logic [AW-1:0] addr_prev = '0;
   logic [DW-1:0] data_prev = '0;

   always @(negedge clk) begin
      // monitor: sdram_ack still holds the previous cycle's value here
      if (!busy) have_prev = 1'b0;
      if (sdram_req && req_prev && !sdram_ack &&
          (sdram_addr != addr_prev || sdram_data_w != data_prev || sdram_rh_wl != rh_prev))
         hold_bad++;
      if (sdram_req && !req_prev) begin
         if (have_prev) begin
            if (prev_rise_wr && low_run != 1) gap_bad++;
            if (!prev_rise_wr && low_run != rd_lat + 1) gap_bad++;
         end else begin
            wr_cnt = 0;
            rd_cnt = 0;
         end
         have_prev     = 1'b1;
         prev_rise_wr  = !sdram_rh_wl;
         last_rise_cyc = cyc;
         low_run       = 0;
      end
      if (!sdram_req) low_run++;
      req_prev  = sdram_req;
      addr_prev = sdram_addr;
      data_prev = sdram_data_w;
      rh_prev   = sdram_rh_wl;

      // controller model
      sdram_ack       = 1'b0;
      sdram_data_r_en = 1'b0;
      if (reset) begin
         ack_wait = 0;
         rd_pend  = 1'b0;
      end else begin
         if (rd_pend) begin
            rd_wait--;
            if (rd_wait == 0) begin
               sdram_data_r_en = 1'b1;
               sdram_data_r    = mem[rd_addr] ^ (corrupt[rd_addr[2:0]] ? 16'h0100 : 16'h0000);
               rd_pend         = 1'b0;
               last_strobe_cyc = cyc;
               rd_cnt++;
            end
         end
         if (sdram_req) begin
            if (!(!sdram_rh_wl && wr_cnt == no_ack_wr)) ack_wait++;
            if (ack_wait == ack_lat) begin
               sdram_ack = 1'b1;
               ack_wait  = 0;
               if (!sdram_rh_wl) begin
                  mem[sdram_addr[7:0]] = sdram_data_w;
                  if (wr_cnt < 16) wr_log[wr_cnt] = sdram_data_w;
                  wr_cnt++;
               end else begin
                  rd_pend = 1'b1;
                  rd_wait = rd_lat;
                  rd_addr = sdram_addr[7:0];
               end
            end
         end
      end
   end

   int checks = 0;
   int errors = 0;
   int done_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_req"}, 32'(sdram_req), 32'd0);
      chk({p, "_rh_wl"}, 32'(sdram_rh_wl), 32'd1);
      chk({p, "_addr"}, 32'(sdram_addr), 32'd0);
      chk({p, "_data_w"}, 32'(sdram_data_w), 32'd0);
      chk({p, "_busy"}, 32'(busy), 32'd0);
      chk({p, "_done"}, 32'(done), 32'd0);
      chk({p, "_pass"}, 32'(pass), 32'd0);
      chk({p, "_timeout"}, 32'(timeout), 32'd0);
      chk({p, "_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({p, "_first_err"}, 32'(first_err_addr), 32'd0);
      chk({p, "_led"}, 32'(led), 32'h00);
   endtask

   // start held high from reset release: first request must be cycle IW+1
   task automatic powerup_check(input string p);
      int first_req = -1;
      int led_bad = 0;
      for (int k = 1; k <= IW + 10; k++) begin
         @(posedge clk); #1;
         if (k <= IW && led !== 8'h00) led_bad++;
         if (sdram_req && first_req < 0) begin
            first_req = k;
            start = 1'b0;
         end
      end
      chk({p, "_first_req_cycle"}, 32'(first_req), 32'(IW + 1));
      chk({p, "_init_led"}, 32'(led_bad), 32'd0);
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [DW-1:0] s);
      @(negedge clk);
      mode  = m;
      seed  = s;
      start = 1'b1;
      @(posedge clk); #1;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_req", 32'(sdram_req), 32'd1);
      chk("start_done_clr", 32'(done), 32'd0);
      chk("start_tmo_clr", 32'(timeout), 32'd0);
      chk("start_led", 32'(led), 32'h01);
      @(negedge clk);
      start = 1'b0;
      mode  = 2'd0;
      seed  = 16'hDEAD;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      done_cyc = cyc;
      chk("done_reached", 32'(done), 32'd1);
   endtask

   initial begin
      // reset values
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");

      // power-up wait + clean pass, mode 1 seed F055, latency 3/3
      @(negedge clk);
      mode  = 2'd1;
      seed  = 16'hF055;
      start = 1'b1;
      reset = 1'b0;
      powerup_check("pwr");
      wait_done(600);
      chk("clean_done_latency", 32'(done_cyc - last_strobe_cyc), 32'd2);
      chk("clean_busy", 32'(busy), 32'd0);
      chk("clean_pass", 32'(pass), 32'd1);
      chk("clean_err", 32'(err_cnt), 32'd0);
      chk("clean_led", 32'(led), 32'h55);
      chk("clean_wr_cnt", 32'(wr_cnt), 32'd8);
      chk("clean_rd_cnt", 32'(rd_cnt), 32'd8);
      for (int i = 0; i < 8; i++)
         chk("clean_wdata", 32'(wr_log[i]), 32'(16'hF055 + 16'(i)));

      // injected read faults at addresses 3 and 6
      corrupt = 8'b0100_1000;
      pulse_start(2'd1, 16'hF055);
      wait_done(600);
      chk("fault_err", 32'(err_cnt), 32'd2);
      chk("fault_first", 32'(first_err_addr), 32'd3);
      chk("fault_pass", 32'(pass), 32'd0);
      chk("fault_led", 32'(led), 32'hAA);
      chk("fault_tmo", 32'(timeout), 32'd0);

      // mode 3 alternating, ack in the request's first cycle, read latency 1
      corrupt = 8'h00;
      ack_lat = 1;
      rd_lat  = 1;
      pulse_start(2'd3, 16'h00FF);
      wait_done(400);
      chk("m3_w0", 32'(wr_log[0]), 32'h00FF);
      chk("m3_w1", 32'(wr_log[1]), 32'hFF00);
      chk("m3_w6", 32'(wr_log[6]), 32'h00FF);
      chk("m3_w7", 32'(wr_log[7]), 32'hFF00);
      chk("m3_pass", 32'(pass), 32'd1);
      chk("m3_done_latency", 32'(done_cyc - last_strobe_cyc), 32'd2);

      // mode 1 wrap-around
      ack_lat = 2;
      rd_lat  = 2;
      pulse_start(2'd1, 16'hFFFE);
      wait_done(500);
      chk("m1w_w0", 32'(wr_log[0]), 32'hFFFE);
      chk("m1w_w1", 32'(wr_log[1]), 32'hFFFF);
      chk("m1w_w2", 32'(wr_log[2]), 32'h0000);
      chk("m1w_w3", 32'(wr_log[3]), 32'h0001);
      chk("m1w_pass", 32'(pass), 32'd1);

      // mode 2 seed xor address
      pulse_start(2'd2, 16'hA5A5);
      wait_done(500);
      chk("m2_w2", 32'(wr_log[2]), 32'hA5A7);
      chk("m2_w5", 32'(wr_log[5]), 32'hA5A0);
      chk("m2_pass", 32'(pass), 32'd1);

      // mode 0, five corrupted words saturate a 2-bit counter at 3
      ack_lat = 3;
      rd_lat  = 3;
      corrupt = 8'h1F;
      pulse_start(2'd0, 16'h1234);
      wait_done(600);
      chk("sat_w4", 32'(wr_log[4]), 32'h1234);
      chk("sat_err", 32'(err_cnt), 32'd3);
      chk("sat_first", 32'(first_err_addr), 32'd0);
      chk("sat_led", 32'(led), 32'hAA);

      // timeout: 5th write never acked
      corrupt   = 8'h00;
      no_ack_wr = 4;
      pulse_start(2'd0, 16'h1111);
      begin
         int n = 0;
         while (!timeout && n < 2000) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("tmo_flag", 32'(timeout), 32'd1);
      chk("tmo_latency", 32'(cyc - last_rise_cyc), 32'(TMO));
      chk("tmo_wr_cnt", 32'(wr_cnt), 32'd4);
      chk("tmo_req", 32'(sdram_req), 32'd0);
      @(posedge clk); #1;
      chk("tmo_done", 32'(done), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_pass", 32'(pass), 32'd0);
      chk("tmo_led", 32'(led), 32'hAA);
      no_ack_wr = -1;

      // start during busy is ignored; reset mid-read aborts everything
      pulse_start(2'd0, 16'h1234);
      begin
         int n = 0;
         while (!(sdram_req && sdram_rh_wl) && n < 300) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("rd_reached", 32'(sdram_req && sdram_rh_wl), 32'd1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      chk("busy_start_rh", 32'(sdram_rh_wl), 32'd1);
      chk("busy_start_busy", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      begin
         int n = 0;
         while (sdram_req && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_reset("rst2");
      @(posedge clk); #1;
      @(negedge clk);
      mode  = 2'd0;
      seed  = 16'h4321;
      start = 1'b1;
      reset = 1'b0;
      powerup_check("pwr2");
      wait_done(600);
      chk("post_rst_pass", 32'(pass), 32'd1);
      chk("post_rst_w7", 32'(wr_log[7]), 32'h4321);

      chk("gap_timing", 32'(gap_bad), 32'd0);
      chk("req_hold", 32'(hold_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
